// File: rtl/ame_pkg.sv
// Shared types and sizing constants for the AME parameter-solver datapath.
package ame_pkg;

  typedef enum logic [1:0] {
    IDLE,
    APPROX,
    SHIFT,
    DONE
  } ame_div_state_t;

  localparam int AME_DATA_BITS = 64;
  localparam int AME_EXP_BITS  = $clog2(AME_DATA_BITS);

endpackage

// File: rtl/ame_num_approx.sv
// Approximate log2 of a signed operand: position of the leading one of |x|,
// registered one cycle after comp_init_i.
module ame_num_approx
  import ame_pkg::*;
#(
  parameter int COMP_DATA_BITS = AME_DATA_BITS
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  input  logic                              comp_init_i,
  input  logic [COMP_DATA_BITS-1:0]         comp_data_i,
  output logic                              comp_done_o,
  output logic [$clog2(COMP_DATA_BITS)-1:0] comp_data_o
);

  localparam int W     = COMP_DATA_BITS;
  localparam int EXP_W = $clog2(COMP_DATA_BITS);

  logic [W-1:0]     mag;
  logic [EXP_W-1:0] msb_pos;

  // Unsigned W bits suffice: -(-2^(W-1)) wraps to exactly 2^(W-1).
  always_comb begin
    mag     = comp_data_i[W-1] ? (~comp_data_i + W'(1)) : comp_data_i;
    msb_pos = '0;
    for (int i = 0; i < W; i++) begin
      if (mag[i]) msb_pos = EXP_W'(i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      comp_done_o <= 1'b0;
      comp_data_o <= '0;
    end else begin
      comp_done_o <= comp_init_i;
      if (comp_init_i) comp_data_o <= msb_pos;
    end
  end

endmodule

// File: rtl/ame_approx_div.sv
// Sequential approximate divider: |num| >> log2(|den|) with sign restore.
// Optional round-half-away-from-zero when AME_DIV_ROUND_EN is defined.
module ame_approx_div
  import ame_pkg::*;
#(
  parameter int COMP_DATA_BITS = AME_DATA_BITS
) (
  input  logic                                clk_i,
  input  logic                                rst_n_i,
  input  logic                                div_init_i,
  input  logic signed [COMP_DATA_BITS-1:0]    div_num_i,
  input  logic signed [COMP_DATA_BITS-1:0]    div_den_i,
  output logic                                div_busy_o,
  output logic                                div_done_o,
  output logic signed [COMP_DATA_BITS-1:0]    div_quot_o,
  output logic                                div_zero_o,
  output logic [$clog2(COMP_DATA_BITS)-1:0]   div_exp_o
);

  localparam int W     = COMP_DATA_BITS;
  localparam int EXP_W = $clog2(COMP_DATA_BITS);
  localparam logic [W:0] ONE_EXT = (W+1)'(1);

  // Magnitude at W+1 bits so the most negative operand stays representable.
  function automatic logic [W:0] abs_ext(input logic signed [W-1:0] v);
    logic [W:0] x;
    x = {v[W-1], v};
    return v[W-1] ? (~x + ONE_EXT) : x;
  endfunction

  function automatic logic [W:0] shift_mag(input logic [W:0] mag, input logic [EXP_W-1:0] e);
`ifdef AME_DIV_ROUND_EN
    logic [W:0] half;
    if (e == '0) return mag;
    half = ONE_EXT << (e - EXP_W'(1));
    return (mag + half) >> e;
`else
    return mag >> e;
`endif
  endfunction

  function automatic logic [W-1:0] apply_sign(input logic [W:0] mag, input logic neg);
    logic [W:0] s;
    s = neg ? (~mag + ONE_EXT) : mag;
    return s[W-1:0];
  endfunction

  ame_div_state_t    state;
  logic              comp_init;
  logic              comp_done;
  logic [EXP_W-1:0]  comp_exp;

  logic signed [W-1:0] num_p0;
  logic signed [W-1:0] den_p0;
  logic [EXP_W-1:0]    exp_p1;
  logic [W-1:0]        quot_next;

  ame_num_approx #(
    .COMP_DATA_BITS (COMP_DATA_BITS)
  ) u_num_approx (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .comp_init_i (comp_init),
    .comp_data_i (den_p0),
    .comp_done_o (comp_done),
    .comp_data_o (comp_exp)
  );

  // Stage p0: operands captured on the accepted start pulse.
  always_ff @(posedge clk_i) begin
    if (state == IDLE && div_init_i) begin
      num_p0 <= div_num_i;
      den_p0 <= div_den_i;
    end
  end

  // Stage p1: exponent captured when the approximation completes.
  always_ff @(posedge clk_i) begin
    if (state == APPROX && comp_done) exp_p1 <= comp_exp;
  end

  assign quot_next = apply_sign(shift_mag(abs_ext(num_p0), exp_p1),
                                num_p0[W-1] ^ den_p0[W-1]);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      comp_init  <= 1'b0;
      div_busy_o <= 1'b0;
      div_done_o <= 1'b0;
      div_quot_o <= '0;
      div_zero_o <= 1'b0;
      div_exp_o  <= '0;
    end else begin
      comp_init  <= 1'b0;
      div_done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (div_init_i) begin
            div_busy_o <= 1'b1;
            if (div_den_i == '0) begin
              state      <= DONE;
              div_done_o <= 1'b1;
              div_quot_o <= '0;
              div_zero_o <= 1'b1;
              div_exp_o  <= '0;
            end else begin
              state     <= APPROX;
              comp_init <= 1'b1;
            end
          end
        end
        APPROX: begin
          if (comp_done) state <= SHIFT;
        end
        SHIFT: begin
          state      <= DONE;
          div_done_o <= 1'b1;
          div_quot_o <= quot_next;
          div_zero_o <= 1'b0;
          div_exp_o  <= exp_p1;
        end
        DONE: begin
          state      <= IDLE;
          div_busy_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
